// File: rtl/timer_8bit.sv
// Purpose: 8-bit up/down timer with prescaler, sticky ovf/udf flags and an APB register slave.
// Latency: zero-wait-state APB; read data is combinational in the access phase, writes commit on that edge.
// Backpressure: none; pready is high throughout every access phase and pslverr is never raised.
module timer_8bit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tmr_ovf,
    output logic              tmr_udf
);

    // Register map.
    localparam logic [ADDR_W-1:0] ADDR_TDR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_TCR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TSR = ADDR_W'(2);

    // Only the implemented TCR fields are stored; reserved bits 6,3,2 do not exist.
    typedef struct packed {
        logic       load;
        logic       updown;   // 1 = count down
        logic       en;
        logic [1:0] cks;      // divide by 2 << cks
    } tcr_t;

    logic [DATA_W-1:0] tdr;
    tcr_t              tcr;
    logic [1:0]        tsr;       // {udf, ovf}
    logic [DATA_W-1:0] cnt;
    logic [3:0]        presc;

    logic              access;
    logic              wr_en;
    logic              rd_en;
    logic              wr_tdr;
    logic              wr_tcr;
    logic              wr_tsr;
    logic              cks_change;
    logic              presc_clr;
    logic [3:0]        presc_max;
    logic              tick;
    logic              ovf_evt;
    logic              udf_evt;
    logic [1:0]        tsr_keep;
    logic [DATA_W-1:0] rd_val;

    assign access = psel & penable;
    assign wr_en  = access & pwrite;
    assign rd_en  = access & ~pwrite;
    assign wr_tdr = wr_en & (paddr == ADDR_TDR);
    assign wr_tcr = wr_en & (paddr == ADDR_TCR);
    assign wr_tsr = wr_en & (paddr == ADDR_TSR);

    // A write that changes the divider restarts the prescaler so the new period starts cleanly.
    assign cks_change = wr_tcr & (pwdata[1:0] != tcr.cks);
    assign presc_clr  = ~tcr.en | tcr.load | cks_change;

    // Terminal count of the prescaler is N-1 for N = 2/4/8/16.
    always_comb begin
        presc_max = 4'b0001;
        case (tcr.cks)
            2'b00:   presc_max = 4'b0001;
            2'b01:   presc_max = 4'b0011;
            2'b10:   presc_max = 4'b0111;
            default: presc_max = 4'b1111;
        endcase
    end

    // The tick is derived from registered state, so a mid-count TCR change only matters from the next tick.
    assign tick    = tcr.en & ~tcr.load & (presc == presc_max);
    assign ovf_evt = tick & ~tcr.updown & (cnt == {DATA_W{1'b1}});
    assign udf_evt = tick &  tcr.updown & (cnt == {DATA_W{1'b0}});

    // Writing 0 clears a flag, writing 1 keeps it; a same-cycle set event still wins below.
    assign tsr_keep = wr_tsr ? pwdata[1:0] : 2'b11;

    // Bus-writable registers: TDR and TCR.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr <= '0;
            tcr <= '0;
        end else begin
            if (wr_tdr) begin
                tdr <= pwdata;
            end
            if (wr_tcr) begin
                tcr.load   <= pwdata[7];
                tcr.updown <= pwdata[5];
                tcr.en     <= pwdata[4];
                tcr.cks    <= pwdata[1:0];
            end
        end
    end

    // Free-running modulo-N prescaler, held at zero while stopped, loading, or re-divided.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            presc <= '0;
        end else if (presc_clr || (presc == presc_max)) begin
            presc <= '0;
        end else begin
            presc <= presc + 4'd1;
        end
    end

    // Main counter: load has priority and freezes counting; otherwise step once per tick with wrap-around.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= '0;
        end else if (tcr.load) begin
            cnt <= tdr;
        end else if (tick) begin
            if (tcr.updown) begin
                cnt <= cnt - DATA_W'(1);
            end else begin
                cnt <= cnt + DATA_W'(1);
            end
        end
    end

    // Sticky status flags.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tsr <= '0;
        end else begin
            tsr <= (tsr & tsr_keep) | {udf_evt, ovf_evt};
        end
    end

    // Read mux; unmapped addresses and reserved bits return zero.
    always_comb begin
        rd_val = '0;
        case (paddr)
            ADDR_TDR: rd_val = tdr;
            ADDR_TCR: rd_val = {tcr.load, 1'b0, tcr.updown, tcr.en, 2'b00, tcr.cks};
            ADDR_TSR: rd_val = {{(DATA_W-2){1'b0}}, tsr};
            default:  rd_val = '0;
        endcase
    end

    assign prdata  = rd_en ? rd_val : '0;
    assign pready  = access;
    assign pslverr = 1'b0;
    assign tmr_ovf = tsr[0];
    assign tmr_udf = tsr[1];

endmodule

// File: tb/tb_timer_8bit.sv
// Purpose: self-checking bench for timer_8bit covering register access, count timing, flags and reset.
// Latency: APB transfers take two pclk; expected flag times come from the (D+1)*N timing rule.
// Backpressure: the DUT never stalls, so every wait is bounded by a local cycle count.
module tb_timer_8bit;

    logic       pclk    = 1'b0;
    logic       presetn = 1'b0;
    logic       psel    = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] paddr   = 8'h00;
    logic [7:0] pwdata  = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    logic [7:0] rd_v;
    logic       rd_rdy;
    logic       rd_err;

    timer_8bit #(.ADDR_W(8), .DATA_W(8)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Write commits on the third posedge; returns 1 time unit after that edge.
    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Called k edges after a reference point, samples state after edge k+2, returns after edge k+3.
    task automatic apb_read(input logic [7:0] a, output logic [7:0] d,
                            output logic rdy, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        d = prdata; rdy = pready; err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Advance until m edges have passed since base (bounded by m itself).
    task automatic wait_until(input int unsigned base, input int m);
        while (int'(cyc - base) < m) begin
            @(posedge pclk); #1;
        end
    endtask

    // Reference rule: after a load then start, the underflow flag is visible once k >= (D+1)*N edges.
    function automatic int exp_udf(input int d, input int n, input int k);
        return (k >= (d + 1) * n) ? 1 : 0;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        int d;
        int t;
        int r;

        vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h01, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'h02, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h03, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h00, 8'hA5, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'hA5};
        vecs[6]  = '{1'b1, 8'h01, 8'hFF, 8'h00};
        vecs[7]  = '{1'b0, 8'h01, 8'h00, 8'hB3};
        vecs[8]  = '{1'b1, 8'h01, 8'h4C, 8'h00};
        vecs[9]  = '{1'b0, 8'h01, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 8'h03, 8'h77, 8'h00};
        vecs[11] = '{1'b0, 8'h03, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 8'hA5};
        vecs[13] = '{1'b1, 8'h02, 8'hFF, 8'h00};
        vecs[14] = '{1'b0, 8'h02, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 8'hFF, 8'h00, 8'h00};

        // Reset state while presetn is low.
        #2;
        check("rst_prdata", prdata, 0);
        check("rst_pready", pready, 0);
        check("rst_ovf", tmr_ovf, 0);
        check("rst_udf", tmr_udf, 0);
        #20;
        presetn = 1'b1;

        // Register access table.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].dat);
            end else begin
                apb_read(vecs[i].addr, rd_v, rd_rdy, rd_err);
                check($sformatf("vec%0d_data", i), rd_v, vecs[i].exp);
                check($sformatf("vec%0d_pready", i), rd_rdy, 1);
                check($sformatf("vec%0d_pslverr", i), rd_err, 0);
            end
        end

        // Overflow: FE up by /2 wraps at edge 4; then switch to down mid-count.
        apb_write(8'h00, 8'hFE);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        c0 = cyc;
        wait_until(c0, 3);
        check("ovf_early", tmr_ovf, 0);
        wait_until(c0, 4);
        check("ovf_set", tmr_ovf, 1);
        // Commits at edge 7; the up tick at edge 6 makes 0x01, down ticks at 8 and 10 give 0x00 then underflow.
        apb_write(8'h01, 8'h30);
        wait_until(c0, 9);
        check("dir_udf_early", tmr_udf, 0);
        wait_until(c0, 10);
        check("dir_udf_set", tmr_udf, 1);
        check("dir_ovf_sticky", tmr_ovf, 1);

        // Flag clearing.
        apb_write(8'h01, 8'h00);
        apb_read(8'h02, rd_v, rd_rdy, rd_err);
        check("tsr_both", rd_v, 8'h03);
        apb_write(8'h02, 8'h02);
        apb_read(8'h02, rd_v, rd_rdy, rd_err);
        check("tsr_clr_ovf", rd_v, 8'h02);
        check("tsr_clr_ovf_pin", tmr_ovf, 0);
        check("tsr_keep_udf_pin", tmr_udf, 1);
        apb_write(8'h02, 8'h00);
        apb_read(8'h02, rd_v, rd_rdy, rd_err);
        check("tsr_clr_all", rd_v, 8'h00);
        check("tsr_clr_udf_pin", tmr_udf, 0);
        apb_write(8'h02, 8'hFF);
        apb_read(8'h02, rd_v, rd_rdy, rd_err);
        check("tsr_w1_noeffect", rd_v, 8'h00);

        // Randomized underflow timing against the (D+1)*N rule, N = 4.
        for (int it = 0; it < 110; it++) begin
            d = (it < 55) ? int'($urandom_range(255, 1)) : int'($urandom_range(64, 1));
            apb_write(8'h01, 8'h00);
            apb_write(8'h02, 8'h00);
            apb_write(8'h00, d[7:0]);
            apb_write(8'h01, 8'h80);
            apb_write(8'h01, 8'h31);
            c0 = cyc;
            t = (d + 1) * 4;
            r = int'($urandom_range(t - 4, 2));
            wait_until(c0, r - 2);
            apb_read(8'h02, rd_v, rd_rdy, rd_err);
            check($sformatf("rnd%0d_d%0d_early", it, d), rd_v, exp_udf(d, 4, r) << 1);
            wait_until(c0, t - 3);
            apb_read(8'h02, rd_v, rd_rdy, rd_err);
            check($sformatf("rnd%0d_d%0d_edge_m1", it, d), rd_v, exp_udf(d, 4, t - 1) << 1);
            check($sformatf("rnd%0d_d%0d_pin", it, d), tmr_udf, exp_udf(d, 4, int'(cyc - c0)));
            apb_read(8'h02, rd_v, rd_rdy, rd_err);
            check($sformatf("rnd%0d_d%0d_late", it, d), rd_v, exp_udf(d, 4, t + 2) << 1);
        end

        // Asynchronous reset mid-count: flag set at edge 4 with D=1, N=2.
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h00);
        apb_write(8'h00, 8'h01);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h30);
        c0 = cyc;
        wait_until(c0, 6);
        check("pre_rst_udf", tmr_udf, exp_udf(1, 2, 6));
        #2;
        presetn = 1'b0;
        #1;
        check("async_rst_udf", tmr_udf, 0);
        @(negedge pclk);
        presetn = 1'b1;
        apb_read(8'h00, rd_v, rd_rdy, rd_err);
        check("post_rst_tdr", rd_v, 8'h00);
        apb_read(8'h01, rd_v, rd_rdy, rd_err);
        check("post_rst_tcr", rd_v, 8'h00);
        apb_read(8'h02, rd_v, rd_rdy, rd_err);
        check("post_rst_tsr", rd_v, 8'h00);

        // Down with en=0: a single tick would underflow the zero counter, so no flag means no tick.
        apb_write(8'h01, 8'h20);
        c0 = cyc;
        wait_until(c0, 40);
        check("no_tick_en0", tmr_udf, 0);
        // Enabling now: counter is 0 after reset, so the first tick (edge 2) underflows.
        apb_write(8'h01, 8'h30);
        c0 = cyc;
        wait_until(c0, 1);
        check("post_rst_first_tick_early", tmr_udf, 0);
        wait_until(c0, 2);
        check("post_rst_first_tick", tmr_udf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
